dino_renderer: RTL and testbench

Pixel-generation stage directly downstream of the VGA timing generator. It takes the raw `haddress`/`vaddress` counters and sync pulses and produces 12-bit RGB for the Chrome-dino scene: background, ground line, dino box and one scrolling cactus. It also owns the per-frame game state: jump FSM, obstacle scroll and collision latch. Outputs go straight to the VGA DAC pins, with sync re-aligned to the pixel pipeline.

---
 rtl/dino_pkg.sv | 22 ++
 rtl/dino_motion.sv | 99 +++++++++
 rtl/dino_renderer.sv | 148 ++++++++++++++
 tb/tb_dino_renderer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants and types for the dino scene renderer: visible-area
// limits, the frame-tick row, scene colours and the jump FSM state encoding.
package dino_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int TICK_V    = 480;

  // 12-bit {R,G,B} colours, highest priority first
  localparam logic [11:0] C_DINO   = 12'h555;
  localparam logic [11:0] C_CACTUS = 12'h0A0;
  localparam logic [11:0] C_GROUND = 12'h840;
  localparam logic [11:0] C_BG     = 12'hFFF;
  localparam logic [11:0] C_BLANK  = 12'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } jump_state_t;

endpackage

// File: rtl/dino_motion.sv
// Per-frame game state: jump FSM with its height counter and the scrolling
// obstacle column. Everything advances only on the frame tick, and a set
// collision latch freezes all of it until reset.
module dino_motion
  import dino_pkg::*;
#(
  parameter int JUMP_H    = 64,
  parameter int JUMP_STEP = 4,
  parameter int SPEED     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_jump,
  input  logic       i_hit,
  output logic [6:0] o_height,
  output logic [9:0] o_obs_x,
  output logic [1:0] o_state
);

  localparam logic [6:0] STEP7   = 7'(JUMP_STEP);
  localparam logic [6:0] PEAK7   = 7'(JUMP_H);
  localparam logic [9:0] SPEED10 = 10'(SPEED);
  localparam logic [9:0] RELOAD  = 10'(H_VISIBLE);

  jump_state_t r_state;
  jump_state_t w_state_next;
  logic [6:0]  r_height;
  logic [6:0]  w_height_next;
  logic [9:0]  r_obs_x;
  logic [9:0]  w_obs_x_next;
  logic        w_advance;
  logic [6:0]  w_height_up;
  logic [6:0]  w_height_dn;

  // A tick only counts while no collision has been latched
  assign w_advance   = i_tick & ~i_hit;
  assign w_height_up = r_height + STEP7;
  assign w_height_dn = r_height - STEP7;

  // State, height and obstacle registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_height <= '0;
      r_obs_x  <= RELOAD;
    end else begin
      r_state  <= w_state_next;
      r_height <= w_height_next;
      r_obs_x  <= w_obs_x_next;
    end
  end

  // Jump FSM: the launch tick already moves the dino up one step, so the
  // peak is reached JUMP_H/JUMP_STEP ticks after launch. jump is only
  // looked at in IDLE, so a held request relaunches right after landing.
  always_comb begin
    w_state_next  = r_state;
    w_height_next = r_height;
    case (r_state)
      IDLE: begin
        if (w_advance && i_jump) begin
          w_height_next = STEP7;
          w_state_next  = (STEP7 == PEAK7) ? FALL : RISE;
        end
      end
      RISE: begin
        if (w_advance) begin
          w_height_next = w_height_up;
          if (w_height_up == PEAK7) w_state_next = FALL;
        end
      end
      FALL: begin
        if (w_advance) begin
          w_height_next = w_height_dn;
          if (w_height_dn == 7'd0) w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_height_next = '0;
      end
    endcase
  end

  // Obstacle scroll: reload before the subtraction could wrap below zero
  always_comb begin
    w_obs_x_next = r_obs_x;
    if (w_advance) begin
      if (r_obs_x < SPEED10) w_obs_x_next = RELOAD;
      else                   w_obs_x_next = r_obs_x - SPEED10;
    end
  end

  assign o_height = r_height;
  assign o_obs_x  = r_obs_x;
  assign o_state  = r_state;

endmodule

// File: rtl/dino_renderer.sv
// Pixel stage behind the VGA timing generator. Stage 1 evaluates the region
// and shape membership of the incoming address; stage 2 resolves colour
// priority and latches collisions. Syncs ride the same two register stages
// so they stay aligned with rgb at the DAC.
module dino_renderer
  import dino_pkg::*;
#(
  parameter int GROUND_Y  = 400,
  parameter int DINO_X    = 64,
  parameter int JUMP_H    = 64,
  parameter int JUMP_STEP = 4,
  parameter int SPEED     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  haddress,
  input  logic [9:0]  vaddress,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        jump,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        hit,
  output logic [1:0]  dbg_jump_state
);

  localparam logic [9:0]  H_VIS10    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS10    = 10'(V_VISIBLE);
  localparam logic [9:0]  TICK_V10   = 10'(TICK_V);
  localparam logic [9:0]  DINO_X_LO  = 10'(DINO_X);
  localparam logic [9:0]  DINO_X_HI  = 10'(DINO_X + 15);
  // Dino rows are compared as (v + height) so the top edge never underflows
  localparam logic [10:0] DINO_VH_LO = 11'(GROUND_Y - 16);
  localparam logic [10:0] DINO_VH_HI = 11'(GROUND_Y - 1);
  localparam logic [9:0]  CACT_Y_LO  = 10'(GROUND_Y - 24);
  localparam logic [9:0]  CACT_Y_HI  = 10'(GROUND_Y - 1);
  localparam logic [9:0]  GROUND_Y0  = 10'(GROUND_Y);
  localparam logic [9:0]  GROUND_Y1  = 10'(GROUND_Y + 1);

  logic        w_tick;
  logic [6:0]  w_height;
  logic [9:0]  w_obs_x;
  logic [1:0]  w_jump_state;
  logic        w_visible;
  logic [10:0] w_vh;
  logic [10:0] w_obs_end;
  logic        w_in_dino;
  logic        w_in_cactus;
  logic        w_in_ground;

  logic        r1_visible;
  logic        r1_dino;
  logic        r1_cactus;
  logic        r1_ground;
  logic        r1_hsync;
  logic        r1_vsync;

  logic [11:0] w_rgb_next;
  logic        w_overlap;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hit;

  // Start of vertical blank: game state may move without tearing the picture
  assign w_tick = (haddress == 10'd0) && (vaddress == TICK_V10);

  dino_motion #(
    .JUMP_H   (JUMP_H),
    .JUMP_STEP(JUMP_STEP),
    .SPEED    (SPEED)
  ) u_motion (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_tick  (w_tick),
    .i_jump  (jump),
    .i_hit   (r_hit),
    .o_height(w_height),
    .o_obs_x (w_obs_x),
    .o_state (w_jump_state)
  );

  // Membership tests on the raw address; cactus columns past 639 fall
  // outside the visible region and are therefore clipped for free
  assign w_visible   = (haddress < H_VIS10) && (vaddress < V_VIS10);
  assign w_vh        = {1'b0, vaddress} + {4'b0000, w_height};
  assign w_obs_end   = {1'b0, w_obs_x} + 11'd7;
  assign w_in_dino   = (haddress >= DINO_X_LO) && (haddress <= DINO_X_HI) &&
                       (w_vh >= DINO_VH_LO) && (w_vh <= DINO_VH_HI);
  assign w_in_cactus = (haddress >= w_obs_x) && ({1'b0, haddress} <= w_obs_end) &&
                       (vaddress >= CACT_Y_LO) && (vaddress <= CACT_Y_HI);
  assign w_in_ground = (vaddress == GROUND_Y0) || (vaddress == GROUND_Y1);

  // Stage 1: capture region/shape flags and syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_visible <= 1'b0;
      r1_dino    <= 1'b0;
      r1_cactus  <= 1'b0;
      r1_ground  <= 1'b0;
      r1_hsync   <= 1'b1;
      r1_vsync   <= 1'b1;
    end else begin
      r1_visible <= w_visible;
      r1_dino    <= w_in_dino;
      r1_cactus  <= w_in_cactus;
      r1_ground  <= w_in_ground;
      r1_hsync   <= hsync_in;
      r1_vsync   <= vsync_in;
    end
  end

  // Colour priority: dino over cactus over ground over background
  always_comb begin
    w_rgb_next = C_BLANK;
    if (r1_visible) begin
      if (r1_dino)        w_rgb_next = C_DINO;
      else if (r1_cactus) w_rgb_next = C_CACTUS;
      else if (r1_ground) w_rgb_next = C_GROUND;
      else                w_rgb_next = C_BG;
    end
  end

  assign w_overlap = r1_visible & r1_dino & r1_cactus;

  // Stage 2: output pixel, delayed syncs and the sticky collision latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb   <= C_BLANK;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_hit   <= 1'b0;
    end else begin
      r_rgb   <= w_rgb_next;
      r_hsync <= r1_hsync;
      r_vsync <= r1_vsync;
      r_hit   <= r_hit | w_overlap;
    end
  end

  assign rgb            = r_rgb;
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign hit            = r_hit;
  assign dbg_jump_state = w_jump_state;

endmodule

// File: tb/tb_dino_renderer.sv
// Directed bench for dino_renderer: drives individual addresses, keeps a
// small scene model, and scores every output pixel two cycles later.
module tb_dino_renderer;
  import dino_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  haddress = '0;
  logic [9:0]  vaddress = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        jump = 1'b0;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        hit;
  logic [1:0]  dbg_jump_state;

  dino_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .haddress      (haddress),
    .vaddress      (vaddress),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .jump          (jump),
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync),
    .hit           (hit),
    .dbg_jump_state(dbg_jump_state)
  );

  // clock / reset-independent timing
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // scoreboard: {hit, vsync, hsync, rgb} expected at cycle due_q[i]
  logic [14:0] exp_q[$];
  int          due_q[$];
  logic [14:0] sb_exp;
  int          sb_due;

  // scene model
  int   m_height = 0;
  int   m_obs    = 640;
  int   m_state  = 0;
  logic m_hit    = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic m_vis(int h, int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic m_dino(int h, int v);
    return (h >= 64) && (h <= 79) && (v >= 384 - m_height) && (v <= 399 - m_height);
  endfunction

  function automatic logic m_cactus(int h, int v);
    return (h >= m_obs) && (h <= m_obs + 7) && (v >= 376) && (v <= 399);
  endfunction

  function automatic logic [11:0] m_rgb(int h, int v);
    if (!m_vis(h, v))            return 12'h000;
    if (m_dino(h, v))            return 12'h555;
    if (m_cactus(h, v))          return 12'h0A0;
    if (v == 400 || v == 401)    return 12'h840;
    return 12'hFFF;
  endfunction

  task automatic model_tick();
    if (!m_hit) begin
      case (m_state)
        0: if (jump) begin m_height = 4; m_state = 1; end
        1: begin m_height = m_height + 4; if (m_height == 64) m_state = 2; end
        default: begin m_height = m_height - 4; if (m_height == 0) m_state = 0; end
      endcase
      if (m_obs < 4) m_obs = 640;
      else           m_obs = m_obs - 4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: present one address for one cycle and queue its expected output
  task automatic drive(input int h, input int v, input logic hs, input logic vs);
    logic [11:0] e_rgb;
    @(posedge clk); #1;
    haddress = 10'(h);
    vaddress = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    e_rgb = m_rgb(h, v);
    if (m_vis(h, v) && m_dino(h, v) && m_cactus(h, v)) m_hit = 1'b1;
    exp_q.push_back({m_hit, vs, hs, e_rgb});
    due_q.push_back(cyc + 2);
  endtask

  task automatic frame_tick();
    drive(700, 490, 1'b1, 1'b1);
    drive(0, 480, 1'b1, 1'b0);
    model_tick();
    drive(700, 490, 1'b1, 1'b1);
    drive(700, 490, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    m_height = 0; m_obs = 640; m_state = 0; m_hit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_hit", hit, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_height", dut.w_height, 0);
    chk("rst_obs_x", dut.w_obs_x, 640);
    chk("rst_state", dbg_jump_state, IDLE);
  endtask

  // scoreboard checker: compare each queued expectation on its due cycle
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      sb_exp = exp_q.pop_front();
      sb_due = due_q.pop_front();
      total++;
      assert ({hit, vsync, hsync, rgb} === sb_exp && sb_due == cyc) else begin
        bad++;
        $error("FAIL pixel due=%0d at=%0d observed={hit,vs,hs,rgb}=%h expected=%h",
               sb_due, cyc, {hit, vsync, hsync, rgb}, sb_exp);
      end
    end
  end

  initial begin
    // --- reset and latency ---
    do_reset();
    drive(0, 0, 1'b1, 1'b1);        // background
    drive(0, 400, 1'b1, 1'b1);      // ground
    drive(700, 100, 1'b1, 1'b1);    // outside visible
    drive(639, 390, 1'b1, 1'b1);    // cactus at 640 fully clipped
    drive(70, 390, 1'b0, 1'b1);     // dino; hsync_in falls
    drive(100, 401, 1'b0, 1'b1);    // ground second row
    drive(100, 402, 1'b1, 1'b0);    // below ground; vsync_in low
    drive(0, 400, 1'b0, 1'b0);
    // mid-frame reset with both syncs held low
    do_reset();

    // --- jump profile, ignored pulse in RISE, held-jump relaunch ---
    for (int t = 1; t <= 33; t++) begin
      jump = (t == 1) || (t == 5) || (t >= 30);
      frame_tick();
      if (t == 1) begin
        chk("jump_t1_height", dut.w_height, 4);
        chk("jump_t1_state", dbg_jump_state, RISE);
      end
      if (t == 5) chk("jump_t5_height", dut.w_height, 20);
      if (t == 16) begin
        chk("jump_t16_height", dut.w_height, 64);
        chk("jump_t16_state", dbg_jump_state, FALL);
        drive(64, 319, 1'b1, 1'b1);
        drive(64, 320, 1'b1, 1'b1);
        drive(79, 335, 1'b1, 1'b1);
        drive(80, 335, 1'b1, 1'b1);
        drive(64, 336, 1'b1, 1'b1);
      end
      if (t == 32) begin
        chk("jump_t32_height", dut.w_height, 0);
        chk("jump_t32_state", dbg_jump_state, IDLE);
      end
      if (t == 33) chk("jump_relaunch_height", dut.w_height, 4);
    end
    jump = 1'b0;

    // --- scroll and wrap ---
    do_reset();
    for (int t = 1; t <= 161; t++) begin
      frame_tick();
      if (t == 1) begin
        chk("scroll_t1_obs", dut.w_obs_x, 636);
        drive(639, 390, 1'b1, 1'b1);
        drive(640, 390, 1'b1, 1'b1);
        drive(636, 375, 1'b1, 1'b1);
        drive(636, 376, 1'b1, 1'b1);
      end
      if (t == 160) begin
        chk("scroll_t160_obs", dut.w_obs_x, 0);
        drive(0, 390, 1'b1, 1'b1);
        drive(7, 399, 1'b1, 1'b1);
        drive(8, 390, 1'b1, 1'b1);
      end
      if (t == 161) chk("scroll_t161_obs", dut.w_obs_x, 640);
    end

    // --- collision ---
    do_reset();
    for (int t = 1; t <= 140; t++) frame_tick();
    chk("coll_t140_obs", dut.w_obs_x, 80);
    drive(79, 384, 1'b1, 1'b1);
    drive(80, 384, 1'b1, 1'b1);
    frame_tick();
    chk("coll_t141_obs", dut.w_obs_x, 76);
    drive(75, 384, 1'b1, 1'b1);
    drive(76, 383, 1'b1, 1'b1);
    drive(76, 384, 1'b1, 1'b1);     // first overlap
    drive(200, 200, 1'b1, 1'b1);
    drive(200, 200, 1'b1, 1'b1);
    jump = 1'b1;
    frame_tick();
    frame_tick();
    frame_tick();
    jump = 1'b0;
    chk("coll_frozen_obs", dut.w_obs_x, 76);
    chk("coll_frozen_height", dut.w_height, 0);
    chk("coll_frozen_state", dbg_jump_state, IDLE);
    chk("coll_hit_held", hit, 1'b1);
    drive(76, 384, 1'b1, 1'b1);
    do_reset();

    // --- jump clears the cactus ---
    for (int t = 1; t <= 125; t++) frame_tick();
    jump = 1'b1;
    frame_tick();
    jump = 1'b0;
    chk("avoid_t126_obs", dut.w_obs_x, 136);
    chk("avoid_t126_height", dut.w_height, 4);
    for (int t = 127; t <= 157; t++) begin
      frame_tick();
      if (t == 141) begin
        chk("avoid_t141_obs", dut.w_obs_x, 76);
        chk("avoid_t141_height", dut.w_height, 64);
      end
      drive(76, 384, 1'b1, 1'b1);
      drive(79, 399, 1'b1, 1'b1);
      drive(70, 399 - m_height, 1'b1, 1'b1);
      drive(m_obs, 390, 1'b1, 1'b1);
    end
    chk("avoid_t157_height", dut.w_height, 0);
    chk("avoid_t157_obs", dut.w_obs_x, 12);
    chk("avoid_t157_state", dbg_jump_state, IDLE);
    chk("avoid_hit", hit, 1'b0);

    // drain the scoreboard
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", due_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
